// File: rtl/tx_controller_mouth.sv
// tx_controller_mouth: serial frame transmitter.
// Frame layout, MSB first: preamble 16'hAAAA, SFD 8'hAB, {dest_id, my_id}, tx_len,
// payload bytes, and CRC-8 (poly 0x07, init 0x00) computed over the payload bits.
// One bit is driven per clock. All outputs are registered.
// Optional feature: define TX_IFG_EN to add a 16-cycle inter-frame gap after each frame.
module tx_controller_mouth (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         tx_start,
  input  logic [127:0] tx_data,
  input  logic [3:0]   tx_len,
  input  logic [1:0]   dest_id,
  input  logic [1:0]   my_id,
  output logic         tx_line,
  output logic         tx_busy,
  output logic         tx_done,
  output logic         tx_err,
  output logic [3:0]   fsm_state
);

  typedef enum logic [3:0] {
    S_IDLE     = 4'd0,
    S_PREAMBLE = 4'd1,
    S_SFD      = 4'd2,
    S_ADDR     = 4'd3,
    S_LEN      = 4'd4,
    S_PAYLOAD  = 4'd5,
    S_CRC      = 4'd6,
    S_DONE     = 4'd7,
    S_IFG      = 4'd8
  } state_t;

  localparam logic [7:0] SFD_BYTE = 8'hAB;

  state_t         state_r;
  logic [7:0]     cnt_r;
  logic [7:0]     crc_r;
  logic [127:0]   data_r;
  logic [3:0]     len_r;
  logic [3:0]     addr_r;
  logic           line_r;
  logic           busy_r;
  logic           done_r;
  logic           err_r;

  logic [7:0]     pay_last_s;
  logic [7:0]     pay_idx_s;
  logic           pay_first_s;
  logic           pay_next_s;
  logic [2:0]     byte_idx_s;
  logic [1:0]     nib_idx_s;

  // One CRC-8 step (x^8+x^2+x+1) for a single serial input bit.
  function automatic logic [7:0] crc8_step(input logic [7:0] crc, input logic din);
    logic fb;
    fb = crc[7] ^ din;
    crc8_step = {crc[6:0], 1'b0} ^ (fb ? 8'h07 : 8'h00);
  endfunction

  // The serial payload is data_r[8L-1:0] sent MSB first, so payload bit k is data_r[8L-1-k].
  assign pay_last_s  = {1'b0, len_r, 3'b000} - 8'd1;
  assign pay_idx_s   = pay_last_s - cnt_r - 8'd1;
  assign pay_first_s = data_r[pay_last_s[6:0]];
  assign pay_next_s  = data_r[pay_idx_s[6:0]];
  // Index of the next bit inside 8-bit (SFD, CRC) and 4-bit (addr, len) fields.
  assign byte_idx_s  = 3'd6 - cnt_r[2:0];
  assign nib_idx_s   = 2'd2 - cnt_r[1:0];

  // Frame sequencer: tx_line always shows the bit of the state/counter it moves to.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= S_IDLE;
      cnt_r   <= 8'd0;
      crc_r   <= 8'd0;
      data_r  <= 128'd0;
      len_r   <= 4'd0;
      addr_r  <= 4'd0;
      line_r  <= 1'b0;
      busy_r  <= 1'b0;
      done_r  <= 1'b0;
      err_r   <= 1'b0;
    end else begin
      done_r <= 1'b0;
      err_r  <= 1'b0;
      case (state_r)
        S_IDLE: begin
          line_r <= 1'b0;
          busy_r <= 1'b0;
          cnt_r  <= 8'd0;
          if (tx_start) begin
            if (tx_len != 4'd0) begin
              data_r  <= tx_data;
              len_r   <= tx_len;
              addr_r  <= {dest_id, my_id};
              state_r <= S_PREAMBLE;
              line_r  <= 1'b1;
              busy_r  <= 1'b1;
            end else begin
              err_r <= 1'b1;
            end
          end
        end
        S_PREAMBLE: begin
          if (cnt_r == 8'd15) begin
            state_r <= S_SFD;
            cnt_r   <= 8'd0;
            line_r  <= SFD_BYTE[7];
          end else begin
            // 0xAAAA: bit k+1 is 1 exactly when k is odd.
            cnt_r  <= cnt_r + 8'd1;
            line_r <= cnt_r[0];
          end
        end
        S_SFD: begin
          if (cnt_r == 8'd7) begin
            state_r <= S_ADDR;
            cnt_r   <= 8'd0;
            line_r  <= addr_r[3];
          end else begin
            cnt_r  <= cnt_r + 8'd1;
            line_r <= SFD_BYTE[byte_idx_s];
          end
        end
        S_ADDR: begin
          if (cnt_r == 8'd3) begin
            state_r <= S_LEN;
            cnt_r   <= 8'd0;
            line_r  <= len_r[3];
          end else begin
            cnt_r  <= cnt_r + 8'd1;
            line_r <= addr_r[nib_idx_s];
          end
        end
        S_LEN: begin
          if (cnt_r == 8'd3) begin
            // CRC restarts from zero and absorbs the first payload bit as it is driven.
            state_r <= S_PAYLOAD;
            cnt_r   <= 8'd0;
            line_r  <= pay_first_s;
            crc_r   <= crc8_step(8'h00, pay_first_s);
          end else begin
            cnt_r  <= cnt_r + 8'd1;
            line_r <= len_r[nib_idx_s];
          end
        end
        S_PAYLOAD: begin
          if (cnt_r == pay_last_s) begin
            state_r <= S_CRC;
            cnt_r   <= 8'd0;
            line_r  <= crc_r[7];
          end else begin
            cnt_r  <= cnt_r + 8'd1;
            line_r <= pay_next_s;
            crc_r  <= crc8_step(crc_r, pay_next_s);
          end
        end
        S_CRC: begin
          if (cnt_r == 8'd7) begin
            state_r <= S_DONE;
            cnt_r   <= 8'd0;
            line_r  <= 1'b0;
            busy_r  <= 1'b0;
            done_r  <= 1'b1;
          end else begin
            cnt_r  <= cnt_r + 8'd1;
            line_r <= crc_r[byte_idx_s];
          end
        end
        S_DONE: begin
          cnt_r  <= 8'd0;
          line_r <= 1'b0;
`ifdef TX_IFG_EN
          state_r <= S_IFG;
          busy_r  <= 1'b1;
`else
          state_r <= S_IDLE;
          busy_r  <= 1'b0;
`endif
        end
        S_IFG: begin
          line_r <= 1'b0;
          if (cnt_r == 8'd15) begin
            state_r <= S_IDLE;
            cnt_r   <= 8'd0;
            busy_r  <= 1'b0;
          end else begin
            cnt_r  <= cnt_r + 8'd1;
            busy_r <= 1'b1;
          end
        end
        default: begin
          state_r <= S_IDLE;
          cnt_r   <= 8'd0;
          line_r  <= 1'b0;
          busy_r  <= 1'b0;
        end
      endcase
    end
  end

  assign tx_line   = line_r;
  assign tx_busy   = busy_r;
  assign tx_done   = done_r;
  assign tx_err    = err_r;
  assign fsm_state = state_r;

endmodule

// File: tb/tb_tx_controller_mouth.sv
// Bench for tx_controller_mouth: frame-level reference model checked every cycle,
// plus directed scenarios with hand-computed expectations.
module tb_tx_controller_mouth;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         tx_start = 1'b0;
  logic [127:0] tx_data = 128'd0;
  logic [3:0]   tx_len = 4'd0;
  logic [1:0]   dest_id = 2'd0;
  logic [1:0]   my_id = 2'd0;
  logic         tx_line, tx_busy, tx_done, tx_err;
  logic [3:0]   fsm_state;

`ifdef TX_IFG_EN
  localparam int IFG_CYC = 16;
`else
  localparam int IFG_CYC = 0;
`endif

  int checks = 0;
  int errors = 0;

  tx_controller_mouth dut (
    .clk(clk), .rst_n(rst_n), .tx_start(tx_start), .tx_data(tx_data),
    .tx_len(tx_len), .dest_id(dest_id), .my_id(my_id), .tx_line(tx_line),
    .tx_busy(tx_busy), .tx_done(tx_done), .tx_err(tx_err), .fsm_state(fsm_state)
  );

  always #10 clk = ~clk;

  // CRC-8 by polynomial long division of payload(x)*x^8 by 0x107; payload in pl[nbits-1:0].
  function automatic logic [7:0] ref_crc(input logic [127:0] pl, input int nbits);
    logic [135:0] r;
    r = {pl, 8'h00};
    for (int i = nbits + 7; i >= 8; i--)
      if (r[i]) r[i -: 9] = r[i -: 9] ^ 9'h107;
    return r[7:0];
  endfunction

  // ---------------- reference model ----------------
  int   m_phase = 0;   // 0 idle, 1 sending bits, 2 done cycle, 3 gap
  bit   m_bits[$];
  int   m_idx = 0;
  int   m_gap = 0;
  int   m_len = 0;
  logic m_err = 1'b0;
  logic e_line = 1'b0, e_busy = 1'b0, e_done = 1'b0, e_err = 1'b0;
  logic [3:0] e_state = 4'd0;

  task automatic build_frame();
    logic [15:0] pre;
    logic [15:0] hdr;
    logic [7:0]  crc;
    pre = 16'hAAAA;
    hdr = {8'hAB, dest_id, my_id, tx_len};
    m_len = int'(tx_len);
    crc = ref_crc(tx_data, 8 * m_len);
    m_bits.delete();
    for (int b = 15; b >= 0; b--) m_bits.push_back(pre[b]);
    for (int b = 15; b >= 0; b--) m_bits.push_back(hdr[b]);
    for (int k = 1; k <= m_len; k++)
      for (int b = 7; b >= 0; b--) m_bits.push_back(tx_data[8 * (m_len - k) + b]);
    for (int b = 7; b >= 0; b--) m_bits.push_back(crc[b]);
  endtask

  initial begin : model
    forever begin
      @(posedge clk or negedge rst_n);
      m_err = 1'b0;
      if (!rst_n) begin
        m_phase = 0;
        m_idx   = 0;
        m_gap   = 0;
      end else begin
        case (m_phase)
          0: if (tx_start) begin
               if (tx_len == 4'd0) m_err = 1'b1;
               else begin build_frame(); m_idx = 0; m_phase = 1; end
             end
          1: begin m_idx++; if (m_idx == m_bits.size()) m_phase = 2; end
          2: if (IFG_CYC > 0) begin m_phase = 3; m_gap = IFG_CYC; end else m_phase = 0;
          3: begin m_gap--; if (m_gap == 0) m_phase = 0; end
          default: m_phase = 0;
        endcase
      end
      e_line = (m_phase == 1) ? m_bits[m_idx] : 1'b0;
      e_busy = (m_phase == 1) || (m_phase == 3);
      e_done = (m_phase == 2);
      e_err  = m_err;
      if (m_phase == 0)      e_state = 4'd0;
      else if (m_phase == 2) e_state = 4'd7;
      else if (m_phase == 3) e_state = 4'd8;
      else if (m_idx < 16)   e_state = 4'd1;
      else if (m_idx < 24)   e_state = 4'd2;
      else if (m_idx < 28)   e_state = 4'd3;
      else if (m_idx < 32)   e_state = 4'd4;
      else if (m_idx < 32 + 8 * m_len) e_state = 4'd5;
      else                   e_state = 4'd6;
    end
  end

  // Per-cycle comparison of every output against the model.
  initial begin : compare
    forever begin
      @(negedge clk);
      checks++;
      if ({tx_line, tx_busy, tx_done, tx_err, fsm_state} !== {e_line, e_busy, e_done, e_err, e_state}) begin
        errors++;
        $display("FAIL cycle_cmp t=%0t line/busy/done/err/state actual=%b%b%b%b/%0d required=%b%b%b%b/%0d",
                 $time, tx_line, tx_busy, tx_done, tx_err, fsm_state,
                 e_line, e_busy, e_done, e_err, e_state);
      end
    end
  end

  // ---------------- directed helpers ----------------
  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic wait_idle();
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < 64; i++) begin
      if (fsm_state == 4'd0 && !tx_busy) begin ok = 1'b1; break; end
      @(negedge clk);
    end
    chk("wait_idle", 128'(ok), 128'd1);
  endtask

  // Called just after the edge that sampled tx_start; cycle 1 is the first frame bit.
  task automatic capture(output logic [159:0] cap, output int nbits, output int done_cyc);
    cap = 160'd0;
    nbits = 0;
    done_cyc = -1;
    for (int c = 1; c <= 300; c++) begin
      @(negedge clk);
      if (tx_done) begin done_cyc = c; break; end
      if (tx_busy) begin cap = {cap[158:0], tx_line}; nbits++; end
    end
  endtask

  task automatic send(input logic [3:0] len, input logic [127:0] data, input logic [1:0] dst,
                      input logic [1:0] src, output logic [159:0] cap, output int nbits,
                      output int done_cyc);
    wait_idle();
    @(posedge clk); #1;
    tx_start = 1'b1; tx_len = len; tx_data = data; dest_id = dst; my_id = src;
    @(posedge clk); #1;
    tx_start = 1'b0;
    capture(cap, nbits, done_cyc);
  endtask

  initial begin : watchdog
    #1000000;
    $display("FAIL watchdog timeout");
    errors++;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $fatal(1);
  end

  initial begin : stim
    logic [159:0] cap;
    logic [127:0] d;
    int nb, dc, cnt, seen, gap, got;
    int lens [3] = '{3, 8, 14};

    // Reset state
    repeat (3) @(negedge clk);
    chk("reset_outputs", 128'({tx_line, tx_busy, tx_done, tx_err, fsm_state}), 128'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;

    // L=1, 0x01, dest 2, my 1: 48 bits, CRC 0x07, done in cycle 49
    chk("model_crc_01", 128'(ref_crc(128'h01, 8)), 128'h07);
    send(4'd1, 128'h01, 2'd2, 2'd1, cap, nb, dc);
    chk("l1_nbits", 128'(nb), 128'd48);
    chk("l1_frame", 128'(cap[47:0]), 128'hAAAAAB910107);
    chk("l1_done_cycle", 128'(dc), 128'd49);

    // CRC corner values
    chk("model_crc_ff", 128'(ref_crc(128'hFF, 8)), 128'hF3);
    send(4'd1, 128'hFF, 2'd0, 2'd3, cap, nb, dc);
    chk("crc_ff", 128'(cap[7:0]), 128'hF3);
    chk("crc_ff_payload", 128'(cap[15:8]), 128'hFF);
    send(4'd1, 128'h00, 2'd1, 2'd2, cap, nb, dc);
    chk("crc_00", 128'(cap[7:0]), 128'h00);
    chk("crc_00_nbits", 128'(nb), 128'd48);

    // L=15 random payload, decoded as a receiver would
    d = {$urandom(), $urandom(), $urandom(), $urandom()};
    send(4'd15, d, 2'd1, 2'd2, cap, nb, dc);
    chk("l15_nbits", 128'(nb), 128'd160);
    chk("l15_sync", 128'(cap[159:136]), 128'hAAAAAB);
    chk("l15_rx_len", 128'(cap[131:128]), 128'd15);
    chk("l15_sender_id", 128'(cap[133:132]), 128'd2);
    chk("l15_dest_id", 128'(cap[135:134]), 128'd1);
    chk("l15_rx_data", 128'(cap[127:8]), 128'(d[119:0]));
    chk("l15_rx_valid_crc", 128'(cap[7:0]), 128'(ref_crc(128'(cap[127:8]), 120)));
    chk("l15_done_cycle", 128'(dc), 128'd161);

    // Assorted lengths
    foreach (lens[i]) begin
      d = {$urandom(), $urandom(), $urandom(), $urandom()};
      send(4'(lens[i]), d, 2'(i), 2'(3 - i), cap, nb, dc);
      chk("len_nbits", 128'(nb), 128'(40 + 8 * lens[i]));
      chk("len_done_cycle", 128'(dc), 128'(41 + 8 * lens[i]));
      chk("len_crc", 128'(cap[7:0]), 128'(ref_crc(d, 8 * lens[i])));
    end

    // tx_len = 0 is rejected
    wait_idle();
    @(posedge clk); #1;
    tx_start = 1'b1; tx_len = 4'd0;
    @(posedge clk); #1;
    tx_start = 1'b0;
    cnt = 0; seen = 0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (tx_err) cnt++;
      if (tx_busy || tx_line) seen++;
    end
    chk("len0_err_pulses", 128'(cnt), 128'd1);
    chk("len0_no_activity", 128'(seen), 128'd0);

    // Second start at bit 20 with different fields is ignored
    d = 128'hDEADBEEF;
    wait_idle();
    @(posedge clk); #1;
    tx_start = 1'b1; tx_len = 4'd4; tx_data = d; dest_id = 2'd1; my_id = 2'd3;
    @(posedge clk); #1;
    tx_start = 1'b0;
    repeat (19) @(posedge clk);
    #1;
    tx_start = 1'b1; tx_len = 4'd2; tx_data = ~d; dest_id = 2'd0; my_id = 2'd0;
    @(posedge clk); #1;
    tx_start = 1'b0;
    capture(cap, nb, dc);
    chk("ignore_done_cycle", 128'(20 + dc), 128'd73);
    chk("ignore_crc", 128'(cap[7:0]), 128'(ref_crc(d, 32)));
    chk("ignore_payload", 128'(cap[39:8]), 128'hDEADBEEF);

    // Reset at bit 30 aborts; new start accepted right after release
    wait_idle();
    @(posedge clk); #1;
    tx_start = 1'b1; tx_len = 4'd8; tx_data = {$urandom(), $urandom(), $urandom(), $urandom()};
    @(posedge clk); #1;
    tx_start = 1'b0;
    repeat (29) @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    chk("abort_line_now", 128'({tx_line, tx_busy, fsm_state}), 128'd0);
    seen = 0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      if (tx_done) seen++;
    end
    chk("abort_no_done", 128'(seen), 128'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    tx_start = 1'b1; tx_len = 4'd1; tx_data = 128'h01; dest_id = 2'd2; my_id = 2'd1;
    @(posedge clk); #1;
    tx_start = 1'b0;
    capture(cap, nb, dc);
    chk("post_reset_frame", 128'(cap[47:0]), 128'hAAAAAB910107);
    chk("post_reset_done_cycle", 128'(dc), 128'd49);

    // Back-to-back starts with tx_start held high
    wait_idle();
    @(posedge clk); #1;
    tx_start = 1'b1; tx_len = 4'd1; tx_data = 128'h5A; dest_id = 2'd3; my_id = 2'd0;
    got = 0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (tx_done) begin got = 1; break; end
    end
    gap = 0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (tx_line) break;
      gap++;
    end
    tx_start = 1'b0;
    chk("b2b_first_done", 128'(got), 128'd1);
    chk("b2b_idle_gap", 128'(gap), 128'(1 + IFG_CYC));
    got = 0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (tx_done) begin got = 1; break; end
    end
    chk("b2b_second_done", 128'(got), 128'd1);
    wait_idle();
    repeat (4) @(negedge clk);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/tx_controller_mouth.md
TX_CONTROLLER_MOUTH -- requirements
Module: tx_controller_mouth

Interface
REQ-001 clk  input  1  50 MHz system clock; all state changes on rising edge.
REQ-002 rst_n  input  1  asynchronous, active-low reset.
REQ-003 tx_start  input  1  single-cycle request; sampled only in S_IDLE.
REQ-004 tx_data  input  128  payload; byte k of L occupies tx_data[8(L-k)-1 -: 8], first byte at tx_data[8L-1].
REQ-005 tx_len  input  4  payload length in bytes, legal 1..15.
REQ-006 dest_id  input  2  destination ID.
REQ-007 my_id  input  2  source ID.
REQ-008 tx_line  output  1  serial line (GPIO 1); one bit per clk, registered, idle level 0.
REQ-009 tx_busy  output  1  high while any frame bit is being driven.
REQ-010 tx_done  output  1  one-cycle pulse when a frame completes.
REQ-011 tx_err  output  1  one-cycle pulse when a start request is rejected.
REQ-012 fsm_state  output  4  current state encoding, for debug.

Function
REQ-013 Frame, MSB first: preamble 16'hAAAA, SFD 8'hAB, {dest_id, my_id}, tx_len, 8*L payload bits, CRC-8.
REQ-014 Frame length is 40+8L bits; every bit is held on tx_line for exactly one clk.
REQ-015 On tx_start in S_IDLE with tx_len!=0: latch tx_data/tx_len/dest_id/my_id; first preamble bit appears on tx_line the next cycle; tx_busy rises the same cycle.
REQ-016 On tx_start with tx_len==0: no frame sent; tx_err pulses next cycle; stays in S_IDLE.
REQ-017 tx_start while not in S_IDLE is ignored; latched fields do not change mid-frame.
REQ-018 States: S_IDLE(0) -> S_PREAMBLE(1, 16 bits) -> S_SFD(2, 8) -> S_ADDR(3, 4) -> S_LEN(4, 4) -> S_PAYLOAD(5, 8L) -> S_CRC(6, 8) -> S_DONE(7) -> S_IDLE; S_IFG(8) sits between S_DONE and S_IDLE when compiled in (REQ-029).
REQ-019 Single 8-bit bit counter; cleared on every state transition.
REQ-020 CRC-8: polynomial x^8+x^2+x+1 (0x07), init 0x00, no reflection, no final XOR; computed over payload bits only.
REQ-021 CRC register cleared on entry to S_PAYLOAD and advanced once per payload bit, in the same cycle that bit is driven.
REQ-022 CRC value frozen at S_CRC entry and shifted out MSB first.
REQ-023 S_DONE lasts one cycle: tx_line=0, tx_busy=0, tx_done=1.
REQ-024 Outside active frame bits, tx_line=0 and tx_busy=0.

Reset
REQ-025 On rst_n low, immediately: state=S_IDLE, tx_line=0, tx_busy=0, tx_done=0, tx_err=0, counter=0, CRC=0, latched fields=0.
REQ-026 Reset mid-frame aborts the frame with no tx_done; after release the block accepts a new tx_start in the first cycle.
REQ-027 fsm_state resets to 4'd0.

Configuration
REQ-028 Macro TX_IFG_EN selects the inter-frame gap feature.
REQ-029 TX_IFG_EN defined: after S_DONE, hold S_IFG for 16 cycles (tx_line=0, tx_busy=1); tx_start during S_IFG is ignored. TX_IFG_EN undefined: S_DONE returns directly to S_IDLE, so back-to-back frames are separated by one idle cycle.

Verification
REQ-030 L=1, data 0x01, dest=2, my=1 -> 48 bits: AAAA AB, 1001, 0001, 00000001, CRC 0x07; tx_done in cycle 49 after start.
REQ-031 L=1, data 0xFF -> CRC 0xF3; L=1, data 0x00 -> CRC 0x00.
REQ-032 L=15, random data, looped back into the receiver -> rx_valid=1, rx_len=15, rx_data[119:0] matches, sender_id=my_id.
REQ-033 tx_len=0 -> tx_err pulses once, tx_line stays 0, tx_busy stays 0.
REQ-034 tx_start repeated at bit 20 -> ignored, frame unchanged; rst_n low at bit 30 -> tx_line=0 immediately, no tx_done.
REQ-035 Back-to-back starts -> 1 idle cycle between frames without TX_IFG_EN, 17 idle cycles with TX_IFG_EN.
